// File: rtl/route32_3_pkg.sv
// Shared definitions for the 3-way write-side router: target codes and the
// buffered request layout.
package route32_3_pkg;

   localparam int DATA_W = 32;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A     = 2'b00;
   localparam sel_t SEL_B     = 2'b01;
   localparam sel_t SEL_C     = 2'b10;
   localparam sel_t SEL_A_ALT = 2'b11;

   typedef struct packed {
      sel_t              sel;
      logic [DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/route32_3_if.sv
// Source-side and sink-side handshakes of the router, bundled for port lists.
interface route32_3_if
   import route32_3_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
);

   logic                     in_valid;
   logic                     in_ready;
   sel_t                     in_sel;
   logic [WIDTH-1:0]         in_data;

   logic                     a_valid;
   logic                     a_ready;
   logic [WIDTH-1:0]         a_data;
   logic                     b_valid;
   logic                     b_ready;
   logic [WIDTH-1:0]         b_data;
   logic                     c_valid;
   logic                     c_ready;
   logic [WIDTH-1:0]         c_data;

   logic [$clog2(DEPTH):0]   count;

   // Environment side: drives the source request and the sink readies.
   modport master (
      output in_valid, in_sel, in_data, a_ready, b_ready, c_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data, c_valid, c_data, count
   );

   modport slave (
      input  in_valid, in_sel, in_data, a_ready, b_ready, c_ready,
      output in_ready, a_valid, a_data, b_valid, b_data, c_valid, c_data, count
   );

endinterface

// File: rtl/route32_3_sync_fifo.sv
// Single-clock in-order FIFO; push is ignored when full, pop when empty.
module route32_3_sync_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the blocks are evaluated in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap by natural overflow.
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; count gates every read,
   // so stale contents are never observed and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/route32_3.sv
// Routes one buffered 32-bit request stream to sink A, B or C by its select code,
// delivering strictly in order with back-pressure from the head's sink.
module route32_3
   import route32_3_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           reset,
   route32_3_if.slave     bus
);

   typedef struct packed {
      sel_t             sel;
      logic [WIDTH-1:0] data;
   } slot_t;

   slot_t                  wr_slot;
   slot_t                  head;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   a_valid;
   logic                   b_valid;
   logic                   c_valid;
   logic [$clog2(DEPTH):0] count;

   assign wr_slot = '{sel: bus.in_sel, data: bus.in_data};
   assign push    = bus.in_valid && !full;

   route32_3_sync_fifo #(
      .W     ($bits(slot_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wr_slot),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // NOTE: every output of this block is given a default first, so no path
   // through the case leaves a valid unassigned and no latch is inferred.
   always_comb begin
      a_valid = 1'b0;
      b_valid = 1'b0;
      c_valid = 1'b0;
      if (!empty) begin
         unique case (head.sel)
            SEL_B:            b_valid = 1'b1;
            SEL_C:            c_valid = 1'b1;
            SEL_A, SEL_A_ALT: a_valid = 1'b1;
            default:          a_valid = 1'b1;
         endcase
      end
   end

   // Readies of non-selected sinks are masked by their (deasserted) valids.
   assign pop = (a_valid && bus.a_ready) ||
                (b_valid && bus.b_ready) ||
                (c_valid && bus.c_ready);

   assign bus.in_ready = !full;
   assign bus.a_valid  = a_valid;
   assign bus.b_valid  = b_valid;
   assign bus.c_valid  = c_valid;
   assign bus.a_data   = head.data;
   assign bus.b_data   = head.data;
   assign bus.c_data   = head.data;
   assign bus.count    = count;

endmodule

// File: tb/tb_route32_3.sv
// Directed and randomised checks of route32_3: reset, routing per code,
// head-of-line blocking, full/empty boundaries and an in-order scoreboard.
module tb_route32_3;
   import route32_3_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fails = 0;

   route32_3_if #(.WIDTH(DATA_W), .DEPTH(DEPTH)) bus ();

   route32_3 #(.WIDTH(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_sel = 2'b00; bus.in_data = '0;
      bus.a_ready = 1'b1; bus.b_ready = 1'b1; bus.c_ready = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (bus.count !== 2'd0) begin n_fails++; $display("FAIL rst_count_held: got %0d want 0", bus.count); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.a_valid, bus.b_valid, bus.c_valid} !== 3'b000) begin
         n_fails++; $display("FAIL rst_valids: got %b want 000", {bus.a_valid, bus.b_valid, bus.c_valid});
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      n_checks++;
      if (bus.count !== 2'd0) begin n_fails++; $display("FAIL rst_count: got %0d want 0", bus.count); end
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd0 || bus.a_valid !== 1'b0) begin
         n_fails++; $display("FAIL idle: got count=%0d a_valid=%b want 0/0", bus.count, bus.a_valid);
      end
   endtask

   task automatic test_route_b();
      bus.a_ready = 1'b0; bus.b_ready = 1'b1; bus.c_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sel = 2'b01; bus.in_data = 32'h1234_5678;
      #1;
      n_checks++;
      if (bus.b_valid !== 1'b0) begin n_fails++; $display("FAIL b_no_comb_path: got %b want 0", bus.b_valid); end
      next_cycle();
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.b_valid !== 1'b1 || bus.b_data !== 32'h1234_5678) begin
         n_fails++; $display("FAIL b_route: got valid=%b data=%h want 1/12345678", bus.b_valid, bus.b_data);
      end
      n_checks++;
      if (bus.a_valid !== 1'b0 || bus.c_valid !== 1'b0) begin
         n_fails++; $display("FAIL b_others: got a=%b c=%b want 0/0", bus.a_valid, bus.c_valid);
      end
      n_checks++;
      if (bus.count !== 2'd1) begin n_fails++; $display("FAIL b_count1: got %0d want 1", bus.count); end
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd0 || bus.b_valid !== 1'b0) begin
         n_fails++; $display("FAIL b_popped: got count=%0d b_valid=%b want 0/0", bus.count, bus.b_valid);
      end
   endtask

   task automatic test_route_a_alt();
      bus.a_ready = 1'b0; bus.b_ready = 1'b1; bus.c_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_sel = 2'b11; bus.in_data = 32'hDEAD_BEEF;
      next_cycle();
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hDEAD_BEEF) begin
         n_fails++; $display("FAIL a_alt_route: got valid=%b data=%h want 1/deadbeef", bus.a_valid, bus.a_data);
      end
      n_checks++;
      if (bus.b_valid !== 1'b0 || bus.c_valid !== 1'b0) begin
         n_fails++; $display("FAIL a_alt_others: got b=%b c=%b want 0/0", bus.b_valid, bus.c_valid);
      end
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd1 || bus.a_data !== 32'hDEAD_BEEF) begin
         n_fails++; $display("FAIL a_alt_hold: got count=%0d data=%h want 1/deadbeef", bus.count, bus.a_data);
      end
      bus.a_ready = 1'b1;
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd0) begin n_fails++; $display("FAIL a_alt_pop: got %0d want 0", bus.count); end
   endtask

   task automatic test_hol_blocking();
      bus.a_ready = 1'b1; bus.b_ready = 1'b0; bus.c_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sel = 2'b10; bus.in_data = 32'h1;
      next_cycle();
      bus.in_sel = 2'b00; bus.in_data = 32'h2;
      next_cycle();
      bus.in_sel = 2'b00; bus.in_data = 32'h3;
      #1;
      n_checks++;
      if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
         n_fails++; $display("FAIL hol_full: got count=%0d in_ready=%b want 2/0", bus.count, bus.in_ready);
      end
      n_checks++;
      if (bus.c_valid !== 1'b1 || bus.c_data !== 32'h1 || bus.a_valid !== 1'b0) begin
         n_fails++; $display("FAIL hol_head: got c=%b data=%h a=%b want 1/1/0", bus.c_valid, bus.c_data, bus.a_valid);
      end
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd2 || bus.c_data !== 32'h1 || bus.a_valid !== 1'b0) begin
         n_fails++; $display("FAIL hol_stall: got count=%0d data=%h a=%b want 2/1/0", bus.count, bus.c_data, bus.a_valid);
      end
      // Pop from full while the third request is still offered: it must be dropped.
      bus.c_ready = 1'b1;
      next_cycle();
      bus.in_valid = 1'b0; bus.c_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.count !== 2'd1) begin n_fails++; $display("FAIL hol_full_pop: got count=%0d want 1", bus.count); end
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h2 || bus.c_valid !== 1'b0) begin
         n_fails++; $display("FAIL hol_next: got a=%b data=%h c=%b want 1/2/0", bus.a_valid, bus.a_data, bus.c_valid);
      end
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd0 || bus.a_valid !== 1'b0) begin
         n_fails++; $display("FAIL hol_drain: got count=%0d a=%b want 0/0", bus.count, bus.a_valid);
      end
   endtask

   task automatic test_push_pop_same();
      bus.a_ready = 1'b0; bus.b_ready = 1'b1; bus.c_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sel = 2'b01; bus.in_data = 32'hAAAA_0001;
      next_cycle();
      bus.in_sel = 2'b10; bus.in_data = 32'hBBBB_0002;
      #1;
      n_checks++;
      if (bus.count !== 2'd1 || bus.b_valid !== 1'b1 || bus.b_data !== 32'hAAAA_0001) begin
         n_fails++; $display("FAIL pp_before: got count=%0d b=%b data=%h want 1/1/aaaa0001", bus.count, bus.b_valid, bus.b_data);
      end
      next_cycle();
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.count !== 2'd1) begin n_fails++; $display("FAIL pp_count: got %0d want 1", bus.count); end
      n_checks++;
      if (bus.c_valid !== 1'b1 || bus.c_data !== 32'hBBBB_0002 || bus.b_valid !== 1'b0) begin
         n_fails++; $display("FAIL pp_head: got c=%b data=%h b=%b want 1/bbbb0002/0", bus.c_valid, bus.c_data, bus.b_valid);
      end
      bus.c_ready = 1'b1;
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd0) begin n_fails++; $display("FAIL pp_drain: got %0d want 0", bus.count); end
   endtask

   task automatic test_reset_midstream();
      bus.a_ready = 1'b0; bus.b_ready = 1'b0; bus.c_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sel = 2'b10; bus.in_data = 32'h55;
      next_cycle();
      bus.in_data = 32'h66;
      next_cycle();
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.count !== 2'd2) begin n_fails++; $display("FAIL mid_prefill: got %0d want 2", bus.count); end
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if (bus.count !== 2'd0 || {bus.a_valid, bus.b_valid, bus.c_valid} !== 3'b000) begin
         n_fails++; $display("FAIL mid_reset: got count=%0d valids=%b want 0/000",
                             bus.count, {bus.a_valid, bus.b_valid, bus.c_valid});
      end
      @(negedge clk);
      reset = 1'b1;
      bus.c_ready = 1'b1;
      next_cycle(); #1;
      n_checks++;
      if (bus.count !== 2'd0 || bus.c_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fails++; $display("FAIL mid_after: got count=%0d c=%b in_ready=%b want 0/0/1", bus.count, bus.c_valid, bus.in_ready);
      end
   endtask

   task automatic test_random();
      entry_t q[$];
      entry_t hd;
      int     sent = 0;
      int     got = 0;
      int     cycles = 0;
      logic   exp_a, exp_b, exp_c, pop_exp, push_exp;
      bus.in_valid = 1'b0;
      while ((sent < 1000 || q.size() != 0) && cycles < 20000) begin
         if (!bus.in_valid && sent < 1000) begin
            bus.in_sel = 2'($urandom_range(0, 3));
            bus.in_data = $urandom;
            bus.in_valid = 1'b1;
         end
         bus.a_ready = 1'($urandom_range(0, 1));
         bus.b_ready = 1'($urandom_range(0, 1));
         bus.c_ready = 1'($urandom_range(0, 1));
         #1;
         n_checks++;
         if (bus.count !== 2'(q.size()) || bus.in_ready !== (q.size() != DEPTH)) begin
            n_fails++; $display("FAIL rnd_occupancy: got count=%0d in_ready=%b want %0d/%b (cycle %0d)",
                                bus.count, bus.in_ready, q.size(), (q.size() != DEPTH), cycles);
         end
         exp_a = 1'b0; exp_b = 1'b0; exp_c = 1'b0;
         if (q.size() != 0) begin
            hd = q[0];
            if (hd.sel == 2'b01)      exp_b = 1'b1;
            else if (hd.sel == 2'b10) exp_c = 1'b1;
            else                      exp_a = 1'b1;
         end
         n_checks++;
         if ({bus.a_valid, bus.b_valid, bus.c_valid} !== {exp_a, exp_b, exp_c}) begin
            n_fails++; $display("FAIL rnd_valids: got %b want %b (cycle %0d)",
                                {bus.a_valid, bus.b_valid, bus.c_valid}, {exp_a, exp_b, exp_c}, cycles);
         end
         if (q.size() != 0) begin
            n_checks++;
            if ((exp_a && bus.a_data !== hd.data) || (exp_b && bus.b_data !== hd.data) ||
                (exp_c && bus.c_data !== hd.data)) begin
               n_fails++; $display("FAIL rnd_data: got a=%h b=%h c=%h want %h (cycle %0d)",
                                   bus.a_data, bus.b_data, bus.c_data, hd.data, cycles);
            end
         end
         pop_exp  = (exp_a && bus.a_ready) || (exp_b && bus.b_ready) || (exp_c && bus.c_ready);
         push_exp = bus.in_valid && (q.size() != DEPTH);
         @(posedge clk);
         if (pop_exp) begin
            void'(q.pop_front());
            got++;
         end
         if (push_exp) begin
            q.push_back('{sel: bus.in_sel, data: bus.in_data});
            sent++;
         end
         @(negedge clk);
         if (push_exp) bus.in_valid = 1'b0;
         cycles++;
      end
      n_checks++;
      if (cycles >= 20000) begin n_fails++; $display("FAIL rnd_timeout: got %0d cycles want < 20000", cycles); end
      n_checks++;
      if (got != 1000 || sent != 1000) begin
         n_fails++; $display("FAIL rnd_totals: got delivered=%0d sent=%0d want 1000/1000", got, sent);
      end
      #1;
      n_checks++;
      if (bus.count !== 2'd0) begin n_fails++; $display("FAIL rnd_final_count: got %0d want 0", bus.count); end
   endtask

   initial begin
      test_reset();
      test_route_b();
      test_route_a_alt();
      test_hol_blocking();
      test_push_pop_same();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/route32_3.md
Name: route32_3

Overview:
- Write-side counterpart of the datapath's 3-way 32-bit select: one 32-bit source stream is routed to one of three sinks (A/B/C) by a 2-bit select code.
- Sits between the store/write-back source and three consumers (data memory, timer, peripheral port).
- Buffers requests in a small in-order FIFO with valid/ready handshakes on both sides, so a stalled sink back-pressures the source instead of losing data.

Parameters:
- WIDTH, 32, data width of every port.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  source presents a request.
- in_ready  output  1  block accepts the request this cycle.
- in_sel  input  2  target code: 00=A, 01=B, 10=C, 11=A.
- in_data  input  WIDTH  payload.
- a_valid  output  1  head entry is targeted at A.
- a_ready  input  1  A accepts.
- a_data  output  WIDTH  payload to A.
- b_valid, b_ready, b_data  same as A, for sink B.
- c_valid, c_ready, c_data  same as A, for sink C.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - Read pointer, write pointer and count all go to 0.
  - a/b/c_valid=0, in_ready=1 as soon as reset releases.
  - Stored entry contents are don't-care.
  - Reset asserted mid-transfer discards all entries immediately, with no completion.
- Storage: FIFO of {sel[1:0], data[WIDTH-1:0]}.
  - Code 11 is stored as-is and decoded to A at the output, matching the 3-way select.
- Push: in_valid && in_ready at a rising edge writes the entry at the write pointer; the pointer increments modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state, never combinationally on sink ready.
- Head decode, combinational from the registered head entry when count != 0:
  - Exactly one of a/b/c_valid is asserted.
  - The asserted valid is chosen by head sel: 00 or 11 → A, 01 → B, 10 → C.
  - a_data, b_data and c_data all carry the head data. Only the selected valid matters.
- Pop: the selected valid && its ready at a rising edge. The read pointer increments modulo DEPTH.
  - Ready inputs of non-selected sinks are ignored.
- Latency:
  - A request accepted at edge t appears at its sink from t+1 if the FIFO was empty.
  - No combinational path from in_* to any sink output.
- Ordering: strict in-order delivery. A stalled head blocks later entries, even those for other sinks.
- Count update per edge:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, and both take effect (legal only when not full, since in_ready=0 when full).
- Boundaries:
  - Full: in_ready=0 and the input is ignored, even if a pop happens that edge.
  - Empty: all sink valids are 0 and sink readies are ignored.
  - Both pointers wrap from DEPTH-1 to 0.
- Valid stability: once a sink valid is asserted, its data and valid are held until the pop, because they come from registered state.

Decomposition:
- Shared package holds:
  - target code constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_A_ALT=2'b11;
  - a packed entry typedef {sel, data}.
- One natural sub-module: sync_fifo (parameterised WIDTH+2 by DEPTH, push/pop/full/empty/count).
- The routing decode lives in route32_3 itself.

Test Plan:
- Reset then idle: all sink valids 0, in_ready=1, count=0. Assert reset mid-stream with count=2 → count=0 and valids 0 immediately, without waiting for a clock.
- Push sel=01, data=0x12345678 with b_ready=1 → b_valid=1 and b_data=0x12345678 at the next cycle; a/c_valid=0; pops on the following edge; count returns to 0.
- Push sel=11, data=0xDEADBEEF → a_valid=1 and a_data=0xDEADBEEF; c_valid=b_valid=0.
- Hold c_ready=0, push sel=10 0x1 then sel=00 0x2 → count=2 and in_ready=0. A third push of 0x3 is not accepted. a_valid stays 0 while head C is stalled (head-of-line blocking). Release c_ready → C receives 0x1, then A receives 0x2.
- count=1, head for B with b_ready=1, plus a simultaneous push → count stays 1, the new entry becomes head next cycle, and no data is lost.
- Random sel/data stream of 1000 requests with random sink readies (50%) → each sink's scoreboard matches the input order, with 11 counted as A, and there is no duplication or loss.
